// File: rtl/spi_ram_pkg.sv
// Shared command encodings and FSM state type for the SPI-to-RAM burst bridge.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWdata,
        StRdWait,
        StRdata
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Simple dual-port RAM: one synchronous write port, one registered read port,
// contents are never reset.
module spi_ram_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // A same-edge read of the written address returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/spi_ram_burst_slave.sv
// SPI slave bridging to an internal RAM with independent auto-incrementing
// write and read pointers; one command per frame, unlimited data words.
module spi_ram_burst_slave
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);

    localparam int unsigned MAX_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    if (DATA_WIDTH < 2) begin : g_dw_check
        $error("spi_ram_burst_slave: DATA_WIDTH must be at least 2");
    end
    if (64'(MEM_DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_depth_check
        $error("spi_ram_burst_slave: MEM_DEPTH exceeds the address space");
    end

    state_e                r_state;
    logic [1:0]            r_cmd;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_addr_done;
    logic [MAX_W-2:0]      r_rx;
    logic [DATA_WIDTH-1:0] r_tx;
    logic                  r_miso;
    logic                  r_frame_err;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [MAX_W-1:0]      w_rx_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_addr_ok;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_mem_we;

    function automatic logic [ADDR_WIDTH-1:0] f_ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign w_rx_next = {r_rx, MOSI};
    assign w_addr    = w_rx_next[ADDR_WIDTH-1:0];
    assign w_addr_ok = ({1'b0, w_addr} < DEPTH_EXT);
    // A completed word still pending when reset hits is dropped with the pointers.
    assign w_mem_we  = r_we & ~rst;

    assign MISO      = r_miso;
    assign busy      = (r_state != StIdle);
    assign frame_err = r_frame_err;

    spi_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cmd       <= '0;
            r_bit_cnt   <= '0;
            r_addr_done <= 1'b0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_frame_err <= 1'b0;
            r_we        <= 1'b0;
            if (r_we) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end

            if (SS_n) begin
                r_state     <= StIdle;
                r_miso      <= 1'b0;
                r_bit_cnt   <= '0;
                r_addr_done <= 1'b0;
                if ((r_state == StCmd) ||
                    ((r_state == StAddr || r_state == StWdata) && r_bit_cnt != '0)) begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_cmd[1] <= MOSI;
                        r_state  <= StCmd;
                    end
                    StCmd: begin
                        r_cmd[0]  <= MOSI;
                        r_bit_cnt <= '0;
                        case ({r_cmd[1], MOSI})
                            CMD_WR_DATA: r_state <= StWdata;
                            CMD_RD_DATA: r_state <= StRdWait;
                            default:     r_state <= StAddr;
                        endcase
                    end
                    StAddr: begin
                        // Bits beyond the first address in a frame are ignored.
                        if (!r_addr_done) begin
                            r_rx <= w_rx_next[MAX_W-2:0];
                            if (r_bit_cnt == ADDR_LAST) begin
                                r_bit_cnt   <= '0;
                                r_addr_done <= 1'b1;
                                if (!w_addr_ok) begin
                                    r_frame_err <= 1'b1;
                                end else if (r_cmd == CMD_RD_ADDR) begin
                                    r_rd_ptr <= w_addr;
                                end else begin
                                    r_wr_ptr <= w_addr;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    StWdata: begin
                        r_rx <= w_rx_next[MAX_W-2:0];
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt <= '0;
                            r_we      <= 1'b1;
                            r_wdata   <= w_rx_next[DATA_WIDTH-1:0];
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    StRdWait: begin
                        r_state   <= StRdata;
                        r_bit_cnt <= '0;
                    end
                    StRdata: begin
                        // Count 0 is the load edge; the next word's read is already
                        // registered because the pointer moved a full word earlier.
                        if (r_bit_cnt == '0) begin
                            r_miso   <= w_rdata[DATA_WIDTH-1];
                            r_tx     <= {w_rdata[DATA_WIDTH-2:0], 1'b0};
                            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                        end else begin
                            r_miso <= r_tx[DATA_WIDTH-1];
                            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end
                        r_bit_cnt <= (r_bit_cnt == DATA_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Scoreboard bench: three bridge instances (default, 200-deep, 16-bit data) share
// clk/rst/MOSI; each has its own SS_n. Read words are queued and checked by a monitor.
module tb_spi_ram_burst_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       mosi;
    logic [2:0] ss_n;
    logic [2:0] miso;
    logic [2:0] busy;
    logic [2:0] ferr;

    always #5 clk = ~clk;

    spi_ram_burst_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256)) u_a (
        .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi),
        .MISO(miso[0]), .busy(busy[0]), .frame_err(ferr[0])
    );
    spi_ram_burst_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200)) u_b (
        .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi),
        .MISO(miso[1]), .busy(busy[1]), .frame_err(ferr[1])
    );
    spi_ram_burst_slave #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .MEM_DEPTH(16)) u_c (
        .clk(clk), .rst(rst), .SS_n(ss_n[2]), .MOSI(mosi),
        .MISO(miso[2]), .busy(busy[2]), .frame_err(ferr[2])
    );

    typedef struct {
        int          d;
        logic [31:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   dw_of [3] = '{8, 8, 16};
    int   aw_of [3] = '{8, 8, 4};
    int   ferr_cnt [3] = '{0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wr_ptr_of(input int d);
        case (d)
            0:       return 32'(u_a.r_wr_ptr);
            1:       return 32'(u_b.r_wr_ptr);
            default: return 32'(u_c.r_wr_ptr);
        endcase
    endfunction

    function automatic logic [31:0] rd_ptr_of(input int d);
        case (d)
            0:       return 32'(u_a.r_rd_ptr);
            1:       return 32'(u_b.r_rd_ptr);
            default: return 32'(u_c.r_rd_ptr);
        endcase
    endfunction

    // Protocol-level monitor: derives the MISO bit window from SS_n/MOSI alone.
    initial begin
        int          fidx [3];
        logic [1:0]  cmd [3];
        logic [31:0] acc [3];
        logic        s_ss [3];
        logic        s_mosi;
        logic        s_rst;
        logic        show;
        int          pos;
        logic [31:0] mask;
        exp_t        e;
        for (int d = 0; d < 3; d++) begin
            fidx[d] = 0;
            cmd[d]  = 2'b00;
            acc[d]  = '0;
        end
        forever begin
            @(posedge clk);
            s_rst  = rst;
            s_mosi = mosi;
            for (int d = 0; d < 3; d++) s_ss[d] = ss_n[d];
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                show = 1'b0;
                pos  = 0;
                if (ferr[d] === 1'b1) ferr_cnt[d]++;
                if (s_rst || s_ss[d]) begin
                    fidx[d] = 0;
                end else begin
                    if (fidx[d] == 0) cmd[d][1] = s_mosi;
                    if (fidx[d] == 1) cmd[d][0] = s_mosi;
                    if (fidx[d] >= 3 && cmd[d] == 2'b11) begin
                        show = 1'b1;
                        pos  = fidx[d] - 3;
                    end
                    fidx[d]++;
                end
                if (show) begin
                    acc[d] = {acc[d][30:0], miso[d]};
                    if (pos % dw_of[d] == dw_of[d] - 1) begin
                        mask = (32'd1 << dw_of[d]) - 32'd1;
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL rd_word_unexpected dut%0d: got %0h, expected none",
                                     d, acc[d] & mask);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("rd_word_dut%0d", d), acc[d] & mask, e.w);
                            check("rd_word_owner", 32'(d), 32'(e.d));
                        end
                    end
                end else begin
                    check($sformatf("miso_idle_dut%0d", d), 32'(miso[d]), 32'd0);
                end
            end
        end
    end

    task automatic frame(input int d, input logic [63:0] val, input int nbits, input int hold);
        for (int i = nbits - 1; i >= 0; i--) begin
            @(negedge clk);
            ss_n[d] = 1'b0;
            mosi    = val[i];
        end
        repeat (hold) @(negedge clk);
        @(negedge clk);
        ss_n[d] = 1'b1;
        mosi    = 1'b0;
    endtask

    task automatic wr_addr(input int d, input logic [31:0] a);
        frame(d, 64'(a), 2 + aw_of[d], 0);
    endtask

    task automatic rd_addr(input int d, input logic [31:0] a);
        frame(d, (64'd2 << aw_of[d]) | 64'(a), 2 + aw_of[d], 0);
    endtask

    task automatic wr_data(input int d, input int n, input logic [63:0] words);
        frame(d, (64'd1 << (n * dw_of[d])) | words, 2 + n * dw_of[d], 0);
    endtask

    task automatic rd_data(input int d, input int n, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2);
        exp_t e;
        e.d = d;
        e.w = w0;
        exp_q.push_back(e);
        if (n > 1) begin e.w = w1; exp_q.push_back(e); end
        if (n > 2) begin e.w = w2; exp_q.push_back(e); end
        frame(d, 64'd3, 2, 1 + n * dw_of[d]);
    endtask

    // Lets the monitor finish its negedge pass before the stimulus side checks.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_ptrs(input string name, input int d, input logic [31:0] wr,
                            input logic [31:0] rd);
        check({name, "_wr_ptr"}, wr_ptr_of(d), wr);
        check({name, "_rd_ptr"}, rd_ptr_of(d), rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst  = 1'b1;
        ss_n = 3'b111;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_busy_dut%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("reset_ferr_dut%0d", d), 32'(ferr[d]), 32'd0);
            check($sformatf("reset_miso_dut%0d", d), 32'(miso[d]), 32'd0);
            chk_ptrs($sformatf("reset_dut%0d", d), d, 32'd0, 32'd0);
        end
        rst = 1'b0;

        // Burst write then burst read
        wr_addr(0, 32'h10);
        wr_data(0, 3, 64'hA53CFF);
        settle();
        check("burst_wr_ptr", wr_ptr_of(0), 32'h13);
        rd_addr(0, 32'h10);
        check("rd_addr_load", rd_ptr_of(0), 32'h10);
        rd_data(0, 3, 32'hA5, 32'h3C, 32'hFF);
        settle();
        chk_ptrs("burst", 0, 32'h13, 32'h13);
        check("burst_no_ferr", 32'(ferr_cnt[0]), 32'd0);

        // Wrap-around at top of memory
        wr_addr(0, 32'hFF);
        wr_data(0, 2, 64'h1122);
        settle();
        check("wrap_wr_ptr", wr_ptr_of(0), 32'h01);
        rd_addr(0, 32'hFF);
        rd_data(0, 2, 32'h11, 32'h22, 32'h0);
        settle();
        check("wrap_rd_ptr", rd_ptr_of(0), 32'h01);

        // Out-of-range address on the 200-deep instance
        base = ferr_cnt[1];
        wr_addr(1, 32'hC7);
        settle();
        check("oor_c7_wr_ptr", wr_ptr_of(1), 32'hC7);
        check("oor_c7_ferr", 32'(ferr_cnt[1] - base), 32'd0);
        wr_addr(1, 32'hC8);
        settle();
        check("oor_c8_wr_ptr", wr_ptr_of(1), 32'hC7);
        check("oor_c8_ferr", 32'(ferr_cnt[1] - base), 32'd1);
        rd_addr(1, 32'hFF);
        settle();
        check("oor_ff_rd_ptr", rd_ptr_of(1), 32'h00);
        check("oor_ff_ferr", 32'(ferr_cnt[1] - base), 32'd2);
        wr_data(1, 2, 64'h5A6B);
        settle();
        check("depth200_wrap_wr_ptr", wr_ptr_of(1), 32'h01);
        rd_addr(1, 32'hC7);
        rd_data(1, 2, 32'h5A, 32'h6B, 32'h0);

        // Aborted word and cut frames
        wr_addr(0, 32'h20);
        wr_data(0, 1, 64'h77);
        wr_addr(0, 32'h20);
        base = ferr_cnt[0];
        frame(0, (64'd1 << 5) | 64'h16, 7, 0);
        settle();
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_ferr", 32'(ferr_cnt[0] - base), 32'd1);
        check("abort_wr_ptr", wr_ptr_of(0), 32'h20);
        frame(0, 64'h0, 1, 0);
        settle();
        check("cut_cmd_ferr", 32'(ferr_cnt[0] - base), 32'd2);
        frame(0, 64'h0, 2, 0);
        settle();
        check("cut_addr0_ferr", 32'(ferr_cnt[0] - base), 32'd2);
        check("cut_addr0_wr_ptr", wr_ptr_of(0), 32'h20);
        rd_addr(0, 32'h20);
        rd_data(0, 1, 32'h77, 32'h0, 32'h0);

        // Reset during the second word of a read burst
        rd_addr(0, 32'h10);
        begin
            exp_t e;
            e.d = 0;
            e.w = 32'hA5;
            exp_q.push_back(e);
        end
        @(negedge clk); ss_n[0] = 1'b0; mosi = 1'b1;
        @(negedge clk); mosi = 1'b1;
        repeat (12) @(negedge clk);
        base = ferr_cnt[0];
        rst  = 1'b1;
        settle();
        check("rstmid_miso", 32'(miso[0]), 32'd0);
        check("rstmid_busy", 32'(busy[0]), 32'd0);
        chk_ptrs("rstmid", 0, 32'd0, 32'd0);
        rst     = 1'b0;
        ss_n[0] = 1'b1;
        mosi    = 1'b0;
        settle();
        check("rstmid_no_ferr", 32'(ferr_cnt[0] - base), 32'd0);
        rd_data(0, 1, 32'h22, 32'h0, 32'h0);

        // 16-bit data, 4-bit address
        wr_addr(2, 32'hF);
        wr_data(2, 1, 64'hBEEF);
        settle();
        check("w16_wr_ptr", wr_ptr_of(2), 32'h0);
        rd_addr(2, 32'hF);
        rd_data(2, 1, 32'hBEEF, 32'h0, 32'h0);
        settle();
        check("w16_rd_ptr", rd_ptr_of(2), 32'h0);
        check("w16_no_ferr", 32'(ferr_cnt[2]), 32'd0);

        settle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
